// File: rtl/fetch_pkg.sv
// Fetch-stage shared defaults and the queued entry type; no logic, no latency,
// no flow control of its own.
package fetch_pkg;
    localparam int ADDR_W = 8;
    localparam int INSTR_W = 32;
    localparam logic [7:0] RESET_PC = 8'h00;
    localparam int QDEPTH = 2;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries; head is registered storage, so no input reaches it combinationally.
// Push is refused while full unless a pop frees a slot the same cycle; flush dominates push and pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t,
    parameter int  DEPTH   = QDEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  entry_t                     wr_data,
    output entry_t                     head,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // Storage is left as-is: stale words sit behind count == 0 and stay non-X.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register drives imem_addr; fetched words reach out_* one cycle after the push.
// Decoder back-pressure fills the queue and then freezes the PC; a redirect flushes and costs one bubble.
module instr_fetch #(
    parameter int                ADDR_W   = fetch_pkg::ADDR_W,
    parameter int                INSTR_W  = fetch_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC,
    parameter int                QDEPTH   = fetch_pkg::QDEPTH
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_pc_plus4
);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(fetch_pkg::PC_STEP);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] redirect_aligned;
    logic [CW-1:0]     q_count;
    logic              push;
    logic              pop;
    entry_t            wr_entry;
    entry_t            head;

    assign redirect_aligned = redirect_pc & ~ADDR_W'(3);
    assign imem_addr        = pc;
    assign out_valid        = (q_count != '0);
    assign pop              = out_valid && out_ready;
    // Taking out_ready into push lets a full queue keep streaming at one word per cycle.
    assign push             = !redirect_valid && ((q_count != CW'(QDEPTH)) || pop);
    assign wr_entry         = '{instr: imem_rdata, pc: pc};

    assign out_instr    = head.instr;
    assign out_pc       = head.pc;
    assign out_pc_plus4 = head.pc + STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_aligned;
        end else if (push) begin
            pc <= pc + STEP;
        end
    end

    fetch_queue #(
        .entry_t (entry_t),
        .DEPTH   (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .wr_data (wr_entry),
        .head    (head),
        .count   (q_count)
    );
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch stage that owns the program counter, drives the combinational instruction memory address, and buffers fetched words in a 2-entry queue toward the decoder with a valid/ready handshake. It sits directly upstream of the instruction memory (address side) and of the decoder (data side). Branch and jump redirects from execute flush the queue and reload the PC. This lets the core tolerate decoder back-pressure without losing or duplicating instructions.

## Interface
- ADDR_W, 8, byte address width of PC and memory address
- INSTR_W, 32, instruction width
- RESET_PC, 8'h00, PC value loaded on reset; bits [1:0] must be 0
- QDEPTH, 2, instruction queue depth (power of two, ≥2)

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- imem_addr  out  ADDR_W  current PC, to the instruction memory address input
- imem_rdata  in  INSTR_W  instruction word, combinational from memory for imem_addr
- redirect_valid  in  1  execute requests a PC change this cycle
- redirect_pc  in  ADDR_W  target address for the redirect
- out_valid  out  1  queue head holds a valid instruction
- out_ready  in  1  decoder accepts the head this cycle
- out_instr  out  INSTR_W  head instruction
- out_pc  out  ADDR_W  address the head was fetched from
- out_pc_plus4  out  ADDR_W  out_pc + 4, modulo 2^ADDR_W

## Operation
- State: pc register; queue of {instr, pc} entries; count 0..QDEPTH.
- pop = out_valid & out_ready; push = !redirect_valid & (count < QDEPTH | pop).
- On push: enqueue {imem_rdata, pc}; pc <= pc + 4.
- PC arithmetic is ADDR_W-bit unsigned; 0xFC + 4 wraps to 0x00, no flag.
- Redirect (highest priority): queue emptied, count <= 0, pc <= {redirect_pc[ADDR_W-1:2], 2'b00}; no push that cycle; a simultaneous pop is still counted as consumed by the decoder but has no effect on the flushed state.
- Full (count == QDEPTH) and no pop: no push, pc holds, imem_addr stable.
- Full with pop: push and pop same cycle, count unchanged.
- Empty: out_valid = 0; out_instr/out_pc/out_pc_plus4 are don't-care but must not be X after reset (drive from storage).
- Memory default word 0x00000000 is enqueued like any other; fetch never inspects instruction content.
- Reset values: pc = RESET_PC, count = 0, out_valid = 0, imem_addr = RESET_PC, out_instr = 0, out_pc = 0, out_pc_plus4 = 4.
- Reset asserted mid-operation: all queued instructions discarded at that edge; reset dominates redirect.

## Timing
- imem_addr = pc, purely registered; memory read is combinational within the cycle.
- Fetch-to-output latency: 1 cycle (instruction at pc appears at out_* the cycle after its push).
- First out_valid: first cycle after rst deasserts plus one edge.
- Throughput: 1 instruction/cycle with out_ready held high.
- Redirect penalty: out_valid = 0 on the cycle after redirect; target instruction valid one cycle later.
- out_* depend only on registers; out_ready has no combinational path to out_*.
- push depends combinationally on out_ready (enables full-rate flow at depth 2).

## Structure
- Shared package fetch_pkg: ADDR_W, INSTR_W, RESET_PC, QDEPTH defaults; typedef fetch_entry_t {instr, pc}; constant PC_STEP = 4.
- One sub-module: fetch_queue, a synchronous FIFO of fetch_entry_t with push, pop, flush, count, head outputs; flush dominates push.
- PC register, push/pop logic, and redirect alignment stay in instr_fetch.

## Test plan
- Reset release, memory: 0x00→0x0AB00093, 0x04→0x00100523, 0x08→0x00A00103, out_ready=1 -> out_instr sequence 0x0AB00093, 0x00100523, 0x00A00103 on consecutive cycles with out_pc 0x00, 0x04, 0x08.
- out_ready=0 for 5 cycles after reset -> count saturates at 2, imem_addr holds 0x08, out_instr holds 0x0AB00093; release -> 0x00, 0x04, 0x08 delivered, none dropped or duplicated.
- redirect_valid=1, redirect_pc=0x13 while queue full -> next cycle out_valid=0, imem_addr=0x10; following cycle out_pc=0x10.
- Redirect to 0xF8, out_ready=1 -> out_pc 0xF8, 0xFC, 0x00, out_pc_plus4 for 0xFC = 0x00.
- redirect_valid and out_ready both high with queue holding 2 -> queue empty next cycle, no stale entry emerges.
- rst asserted for one cycle mid-stream with redirect_valid=1 -> imem_addr=RESET_PC, out_valid=0, out_pc_plus4=4 the next cycle.
